float_multiplier_pipelined: RTL and testbench
=============================================

// Module: float_multiplier_pipelined
// PURPOSE
//   Parametrised successor to the fixed e4m3/bf16 multipliers: one sign/exponent/mantissa
//   float multiplier for any format, with a 3-stage pipeline and valid/ready handshakes.
//   Accepts one operand pair per cycle. Results return in order.
//   Sits between operand buffers and accumulator logic in the low-precision datapath.
// PARAMETERS
//   EXP_BITS      8  exponent width; bias = 2^(EXP_BITS-1)-1 (e4m3: 4, bf16: 8)
//   MAN_BITS      7  stored mantissa width (e4m3: 3, bf16: 7)
//   IEEE_SPECIALS 1  1: exponent all-ones is Inf/NaN. 0: "fn" style, where only all-ones
//                    exp+mantissa is NaN and overflow saturates to max finite
// PORTS  (W = 1+EXP_BITS+MAN_BITS)
//   clock      in   1  rising-edge clock
//   reset      in   1  asynchronous, active-low reset
//   in_valid   in   1  operand pair a/b valid
//   in_ready   out  1  pipeline can accept; transfer when in_valid & in_ready
//   a          in   W  operand A {sign, exp, man}
//   b          in   W  operand B
//   out_valid  out  1  y holds a result
//   out_ready  in   1  consumer accepts; transfer when out_valid & out_ready
//   y          out  W  product
// BEHAVIOUR
//   - Reset (reset=0, async): all stage valids, out_valid and y cleared to 0. Any in-flight
//     results are discarded, including a reset mid-stall. in_ready=1 while reset is held.
//   - Stages: S1 unpack + (MAN_BITS+1)x(MAN_BITS+1) mantissa product, exponent sum
//     ea+eb-bias (signed, EXP_BITS+2 bits), sign = sa^sb. S2 normalise (product MSB set:
//     shift right 1, exp+1), then round. S3 overflow/underflow/special resolve and pack
//     into the y register.
//   - Latency: 3 cycles from accept to out_valid with no stall; throughput 1 per cycle.
//   - Stall: advance = !out_valid | out_ready. All stages hold when !advance.
//     in_ready = advance (combinational). Bubbles are not compressed.
//   - y and out_valid are stable while out_valid & !out_ready. Simultaneous accept and
//     drain in one cycle is legal and keeps full throughput.
//   - Zero/subnormal: exp==0 inputs flush to zero. Zero x finite = signed zero (sign=sa^sb).
//   - Underflow: biased result exp <= 0 after rounding gives signed zero (no subnormal out).
//   - Overflow: biased exp >= max gives signed Inf (IEEE_SPECIALS=1), or signed max finite
//     exp=all-ones, man=all-ones-1 (IEEE_SPECIALS=0).
//   - NaN in, or Inf x 0, gives canonical NaN: sign 0, exp all-ones, man MSB set
//     (IEEE_SPECIALS=0: man all-ones). Inf x finite-nonzero gives signed Inf.
//   - Mantissa carry-out from rounding increments the exponent, then re-checks overflow.
// CONFIGURATION
//   FMUL_ROUND_RNE_EN defined: round-to-nearest-even in S2. Guard bit = first dropped bit,
//     sticky = OR of the rest; round up if G & (S | LSB).
//   undefined: truncate (drop low product bits). S2 keeps the same latency either way.
// TESTING (run with both IEEE_SPECIALS settings where the format applies)
//   e4m3 (4,3,0): a=0x40 b=0x40 -> y=0x48 after 3 cycles. a=0xAC b=0xC0 -> 0x34.
//     a=0x00 b=0x00 -> 0x00.
//   e4m3 rounding tie: a=0x3C b=0x39 (1.5*1.125=1.6875) -> 0x3E with FMUL_ROUND_RNE_EN,
//     0x3D without.
//   bf16 (8,7,1): 0xBF40*0x3FE0 -> 0xBFA8; 0x3FFF*0x3FE0 -> 0x405F; 0x4348*0x3A83 -> 0x3E4D
//     (RNE on); issued back-to-back, one per cycle, outputs in order on consecutive cycles.
//   Overflow/specials: bf16 0x7F00*0x7F00 -> 0x7F80; 0x7F80*0x0000 -> 0x7FC0;
//     e4m3 IEEE_SPECIALS=0 0x77*0x77 -> 0x7E.
//   Backpressure: stream 5 bf16 pairs with out_ready=0 -> in_ready falls after 3 accepted,
//     y holds the first result. Raise out_ready -> all 5 drain in order, none lost/duplicated.
//   Reset mid-stream: assert reset with 2 ops in flight -> out_valid=0, y=0 at once. After
//     release, first new op appears after 3 cycles.

Source files
------------

// File: rtl/float_multiplier_pipelined.sv
// Generic sign/exponent/mantissa float multiplier (any EXP_BITS/MAN_BITS), optional RNE via FMUL_ROUND_RNE_EN.
// Latency 3 cycles accept-to-out_valid, throughput one pair per cycle, results in order.
// Backpressure: whole pipe holds when out_valid & !out_ready; in_ready = !out_valid | out_ready.
module float_multiplier_pipelined #(
    parameter int EXP_BITS      = 8,
    parameter int MAN_BITS      = 7,
    parameter int IEEE_SPECIALS = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_BITS+MAN_BITS:0] a,
    input  logic [EXP_BITS+MAN_BITS:0] b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_BITS+MAN_BITS:0] y
);
    localparam int EW   = EXP_BITS + 2;          // signed exponent width, covers ea+eb-bias+2
    localparam int PW   = 2 * MAN_BITS + 2;      // full significand product width
    localparam int BIAS = (1 << (EXP_BITS - 1)) - 1;
    localparam int EMAX = (1 << EXP_BITS) - 1;
    localparam bit IEEE = (IEEE_SPECIALS != 0);
`ifdef FMUL_ROUND_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif
    localparam logic [EXP_BITS-1:0]    EXP_ONES = '1;
    localparam logic [MAN_BITS-1:0]    MAN_ONES = '1;
    localparam logic [MAN_BITS-1:0]    MAN_MSB  = {1'b1, {(MAN_BITS-1){1'b0}}};
    localparam logic [MAN_BITS-1:0]    NAN_MAN  = IEEE ? MAN_MSB : MAN_ONES;
    localparam logic [MAN_BITS-1:0]    SAT_MAN  = MAN_ONES - 1'b1;
    localparam logic signed [EW-1:0]   EMAX_S   = EW'(EMAX);

    // ---------------- global stall ----------------
    logic w_adv;
    logic r_out_valid;
    logic [EXP_BITS+MAN_BITS:0] r_y;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign y         = r_y;

    // ---------------- S1: unpack, classify, multiply ----------------
    logic                w_sa, w_sb;
    logic [EXP_BITS-1:0] w_ea, w_eb;
    logic [MAN_BITS-1:0] w_ma, w_mb;
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic w_nan1, w_inf1, w_zero1;
    logic [PW-1:0]        w_prod1;
    logic signed [EW-1:0] w_exp1;

    assign {w_sa, w_ea, w_ma} = a;
    assign {w_sb, w_eb, w_mb} = b;

    // exp==0 covers zero and subnormals, which are flushed
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = IEEE && (w_ea == EXP_ONES) && (w_ma == '0);
    assign w_b_inf  = IEEE && (w_eb == EXP_ONES) && (w_mb == '0);
    assign w_a_nan  = (w_ea == EXP_ONES) && (IEEE ? (w_ma != '0) : (w_ma == MAN_ONES));
    assign w_b_nan  = (w_eb == EXP_ONES) && (IEEE ? (w_mb != '0) : (w_mb == MAN_ONES));

    assign w_nan1  = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
    assign w_inf1  = (w_a_inf || w_b_inf) && !w_nan1;
    assign w_zero1 = (w_a_zero || w_b_zero) && !w_nan1 && !w_inf1;
    assign w_prod1 = PW'({1'b1, w_ma}) * PW'({1'b1, w_mb});
    assign w_exp1  = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);

    logic                 r_v1, r_s1, r_nan1, r_inf1, r_zero1;
    logic [PW-1:0]        r_prod1;
    logic signed [EW-1:0] r_exp1;

    // S1 register: capture operand pair product and class flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v1    <= 1'b0;
            r_s1    <= 1'b0;
            r_nan1  <= 1'b0;
            r_inf1  <= 1'b0;
            r_zero1 <= 1'b0;
            r_prod1 <= '0;
            r_exp1  <= '0;
        end else if (w_adv) begin
            r_v1    <= in_valid;
            r_s1    <= w_sa ^ w_sb;
            r_nan1  <= w_nan1;
            r_inf1  <= w_inf1;
            r_zero1 <= w_zero1;
            r_prod1 <= w_prod1;
            r_exp1  <= w_exp1;
        end
    end

    // ---------------- S2: normalise and round ----------------
    logic [PW-1:0]        w_norm;
    logic signed [EW-1:0] w_exp_n, w_exp2;
    logic [MAN_BITS-1:0]  w_man_t;
    logic                 w_guard, w_sticky, w_rnd_up;
    logic [MAN_BITS:0]    w_man_r;

    // product is in [1,4): align so the hidden bit sits at the MSB
    assign w_norm   = r_prod1[PW-1] ? r_prod1 : (r_prod1 << 1);
    assign w_exp_n  = r_exp1 + EW'(r_prod1[PW-1]);
    assign w_man_t  = w_norm[PW-2 -: MAN_BITS];
    assign w_guard  = w_norm[MAN_BITS];
    assign w_sticky = |w_norm[MAN_BITS-1:0];
    assign w_rnd_up = RNE && w_guard && (w_sticky || w_man_t[0]);
    // carry out of the mantissa leaves it zero and bumps the exponent
    assign w_man_r  = {1'b0, w_man_t} + (MAN_BITS+1)'(w_rnd_up);
    assign w_exp2   = w_exp_n + EW'(w_man_r[MAN_BITS]);

    logic                 r_v2, r_s2, r_nan2, r_inf2, r_zero2;
    logic [MAN_BITS-1:0]  r_man2;
    logic signed [EW-1:0] r_exp2;

    // S2 register: rounded mantissa and final unclamped exponent
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v2    <= 1'b0;
            r_s2    <= 1'b0;
            r_nan2  <= 1'b0;
            r_inf2  <= 1'b0;
            r_zero2 <= 1'b0;
            r_man2  <= '0;
            r_exp2  <= '0;
        end else if (w_adv) begin
            r_v2    <= r_v1;
            r_s2    <= r_s1;
            r_nan2  <= r_nan1;
            r_inf2  <= r_inf1;
            r_zero2 <= r_zero1;
            r_man2  <= w_man_r[MAN_BITS-1:0];
            r_exp2  <= w_exp2;
        end
    end

    // ---------------- S3: range/special resolve and pack ----------------
    logic                       w_unf, w_ovf;
    logic [EXP_BITS+MAN_BITS:0] w_y3;

    assign w_unf = r_exp2[EW-1] || (r_exp2 == '0);
    // fn formats keep exp all-ones as finite except the all-ones NaN code
    assign w_ovf = IEEE ? (r_exp2 >= EMAX_S)
                        : ((r_exp2 > EMAX_S) || ((r_exp2 == EMAX_S) && (r_man2 == MAN_ONES)));

    // select final encoding: NaN > Inf > zero > underflow > overflow > normal
    always_comb begin
        w_y3 = {r_s2, r_exp2[EXP_BITS-1:0], r_man2};
        if (r_nan2)
            w_y3 = {1'b0, EXP_ONES, NAN_MAN};
        else if (r_inf2)
            w_y3 = {r_s2, EXP_ONES, {MAN_BITS{1'b0}}};
        else if (r_zero2 || w_unf)
            w_y3 = {r_s2, {(EXP_BITS+MAN_BITS){1'b0}}};
        else if (w_ovf)
            w_y3 = IEEE ? {r_s2, EXP_ONES, {MAN_BITS{1'b0}}} : {r_s2, EXP_ONES, SAT_MAN};
    end

    // output register: y only updates when a real result moves in
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_v2;
            if (r_v2)
                r_y <= w_y3;
        end
    end
endmodule

// File: tb/tb_float_multiplier_pipelined.sv
// Bench for float_multiplier_pipelined: bf16 (8,7,1) and e4m3fn (4,3,0) instances side by side.
// Directed table vectors, hand sequences for streaming/backpressure/reset, random stream vs model.
// Rounding expectations follow FMUL_ROUND_RNE_EN as compiled.
module tb_float_multiplier_pipelined;
`ifdef FMUL_ROUND_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        iv[2];
    logic        ordy[2];
    logic [15:0] ia[2];
    logic [15:0] ib[2];
    logic        irdy[2];
    logic        ov[2];
    logic [15:0] yv[2];
    logic [15:0] y_bf;
    logic [7:0]  y_e4;

    assign yv[0] = y_bf;
    assign yv[1] = {8'h00, y_e4};

    float_multiplier_pipelined #(.EXP_BITS(8), .MAN_BITS(7), .IEEE_SPECIALS(1)) u_bf (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(ia[0]), .b(ib[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .y(y_bf));

    float_multiplier_pipelined #(.EXP_BITS(4), .MAN_BITS(3), .IEEE_SPECIALS(0)) u_e4 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(ia[1][7:0]), .b(ib[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .y(y_e4));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // ---------------- reference model: exact integer product, then round to format ----------------
    function automatic logic [15:0] pack(input bit s, input int e, input longint m, input int E, input int M);
        logic [31:0] r;
        r = (32'(s) << (E + M)) | (32'(e) << M) | 32'(m);
        return r[15:0];
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input int E, input int M, input bit ieee);
        int bias, emax, ea, eb, e, sh;
        longint ma, mb, p, keep, rem, half, man, mones;
        bit sa, sb, s, za, zb, ia_, ib_, na, nb;
        bias  = (1 << (E - 1)) - 1;
        emax  = (1 << E) - 1;
        mones = (longint'(1) << M) - 1;
        ma = longint'(a) & mones;  mb = longint'(b) & mones;
        ea = int'(a >> M) & emax;  eb = int'(b >> M) & emax;
        sa = a[E + M];             sb = b[E + M];
        s  = sa ^ sb;
        za = (ea == 0);            zb = (eb == 0);
        ia_ = ieee && ea == emax && ma == 0;
        ib_ = ieee && eb == emax && mb == 0;
        na = (ea == emax) && (ieee ? (ma != 0) : (ma == mones));
        nb = (eb == emax) && (ieee ? (mb != 0) : (mb == mones));
        if (na || nb || (ia_ && zb) || (ib_ && za))
            return pack(1'b0, emax, ieee ? (longint'(1) << (M - 1)) : mones, E, M);
        if (ia_ || ib_) return pack(s, emax, 0, E, M);
        if (za || zb)   return pack(s, 0, 0, E, M);
        // value = p * 2^(ea+eb-2*bias-2M), p in [2^2M, 2^(2M+2))
        p  = ((longint'(1) << M) + ma) * ((longint'(1) << M) + mb);
        sh = (p >= (longint'(1) << (2 * M + 1))) ? M + 1 : M;
        e  = ea + eb - bias + (sh - M);
        keep = p >> sh;
        rem  = p - (keep << sh);
        half = longint'(1) << (sh - 1);
        if (RNE && (rem > half || (rem == half && keep % 2 == 1))) keep++;
        if (keep == (longint'(1) << (M + 1))) begin
            keep = keep >> 1;
            e++;
        end
        man = keep - (longint'(1) << M);
        if (e <= 0) return pack(s, 0, 0, E, M);
        if (ieee && e >= emax) return pack(s, emax, 0, E, M);
        if (!ieee && (e > emax || (e == emax && man == mones))) return pack(s, emax, mones - 1, E, M);
        return pack(s, e, man, E, M);
    endfunction

    function automatic logic [15:0] model(input int d, input logic [15:0] a, input logic [15:0] b);
        if (d == 0) return ref_mul(a, b, 8, 7, 1'b1);
        return ref_mul(a, b, 4, 3, 1'b0);
    endfunction

    // ---------------- scoreboard ----------------
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] pend_a[$];
    logic [15:0] pend_b[$];
    bit mon_en = 1'b0;
    int n_acc[2];
    int n_drn[2];

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [15:0] qpop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int d, input logic [15:0] v);
        if (d == 0) q0.push_back(v);
        else q1.push_back(v);
    endfunction

    // monitor: on the falling edge, judge transfers that the next rising edge commits
    always @(negedge clock) begin
        if (mon_en && reset) begin
            for (int d = 0; d < 2; d++) begin
                if (ov[d] && ordy[d]) begin
                    if (qsize(d) == 0) begin
                        n_tot++;
                        $display("FAIL spurious_out%0d: got %h, expected no output", d, yv[d]);
                    end else begin
                        check($sformatf("stream%0d_y", d), yv[d], qpop(d));
                    end
                    n_drn[d]++;
                end
                if (iv[d] && irdy[d]) begin
                    qpush(d, model(d, ia[d], ib[d]));
                    n_acc[d]++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    // one cycle of the pending-queue driver; operand held until accepted
    task automatic drive_cycle(input int d, input bit rand_rdy);
        bit acc;
        if (pend_a.size() > 0 && !(rand_rdy && $urandom_range(0, 4) == 0)) begin
            iv[d] = 1'b1;
            ia[d] = pend_a[0];
            ib[d] = pend_b[0];
        end else begin
            iv[d] = 1'b0;
        end
        if (rand_rdy) ordy[d] = ($urandom_range(0, 3) != 0);
        @(negedge clock);
        acc = iv[d] && irdy[d];
        cyc();
        if (acc) begin
            void'(pend_a.pop_front());
            void'(pend_b.pop_front());
        end
    endtask

    task automatic run_stream(input int d, input int maxc, input bit rand_rdy, input string nm);
        bit done = 1'b0;
        for (int c = 0; c < maxc && !done; c++) begin
            drive_cycle(d, rand_rdy);
            if (pend_a.size() == 0 && qsize(d) == 0) done = 1'b1;
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        if (!done) begin
            n_tot++;
            $display("FAIL %s_timeout: pending %0d, outstanding %0d, required 0", nm, pend_a.size(), qsize(d));
        end
    endtask

    // single operation: check 3-cycle latency and result
    task automatic one_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input string nm);
        int lat;
        ordy[d] = 1'b1;
        ia[d] = a; ib[d] = b; iv[d] = 1'b1;
        cyc();
        iv[d] = 1'b0;
        lat = 1;
        while (!ov[d] && lat < 10) begin
            cyc();
            lat++;
        end
        check({nm, "_lat"}, 16'(lat), 16'd3);
        check(nm, yv[d], exp);
        cyc();
    endtask

    typedef struct {
        int          d;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int acc0, drn0, ghost;
        logic [15:0] first_exp;

        tbl.push_back('{1, 16'h40,   16'h40,   16'h48,   "e4_2x2"});
        tbl.push_back('{1, 16'hAC,   16'hC0,   16'h34,   "e4_negneg"});
        tbl.push_back('{1, 16'h00,   16'h00,   16'h00,   "e4_zero"});
        tbl.push_back('{1, 16'h3C,   16'h39,   RNE ? 16'h3E : 16'h3D, "e4_tie"});
        tbl.push_back('{1, 16'h77,   16'h77,   16'h7E,   "e4_sat"});
        tbl.push_back('{1, 16'h7F,   16'h38,   16'h7F,   "e4_nan"});
        tbl.push_back('{0, 16'hBF40, 16'h3FE0, 16'hBFA8, "bf_a"});
        tbl.push_back('{0, 16'h3FFF, 16'h3FE0, 16'h405F, "bf_b"});
        tbl.push_back('{0, 16'h4348, 16'h3A83, RNE ? 16'h3E4D : 16'h3E4C, "bf_c"});
        tbl.push_back('{0, 16'h7F00, 16'h7F00, 16'h7F80, "bf_ovf"});
        tbl.push_back('{0, 16'h7F80, 16'h0000, 16'h7FC0, "bf_inf0"});
        tbl.push_back('{0, 16'hFF80, 16'h3F80, 16'hFF80, "bf_inf1"});
        tbl.push_back('{0, 16'h7FC1, 16'h3F80, 16'h7FC0, "bf_nan"});
        tbl.push_back('{0, 16'h8000, 16'h3F80, 16'h8000, "bf_negzero"});
        tbl.push_back('{0, 16'h0080, 16'h0080, 16'h0000, "bf_unf"});

        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; ia[d] = '0; ib[d] = '0;
            n_acc[d] = 0; n_drn[d] = 0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_in_ready%0d", d), 16'(irdy[d]), 16'd1);
            check($sformatf("rst_out_valid%0d", d), 16'(ov[d]), 16'd0);
            check($sformatf("rst_y%0d", d), yv[d], 16'h0000);
        end
        cyc(); cyc();
        reset = 1'b1;
        cyc();

        // directed table
        foreach (tbl[i]) one_op(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].nm);

        // bf16 back-to-back: consecutive outputs
        ordy[0] = 1'b1;
        ia[0] = 16'hBF40; ib[0] = 16'h3FE0; iv[0] = 1'b1; cyc();
        ia[0] = 16'h3FFF; ib[0] = 16'h3FE0; cyc();
        ia[0] = 16'h4348; ib[0] = 16'h3A83; cyc();
        iv[0] = 1'b0;
        check("b2b_v0", 16'(ov[0]), 16'd1); check("b2b_y0", yv[0], 16'hBFA8); cyc();
        check("b2b_v1", 16'(ov[0]), 16'd1); check("b2b_y1", yv[0], 16'h405F); cyc();
        check("b2b_v2", 16'(ov[0]), 16'd1); check("b2b_y2", yv[0], RNE ? 16'h3E4D : 16'h3E4C); cyc();
        check("b2b_idle", 16'(ov[0]), 16'd0);

        // backpressure: 5 pairs against a stalled consumer
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pend_a.push_back(16'h3F80 + 16'(i * 9));
            pend_b.push_back(16'h4000 + 16'(i * 5));
        end
        first_exp = model(0, pend_a[0], pend_b[0]);
        acc0 = n_acc[0]; drn0 = n_drn[0];
        ordy[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive_cycle(0, 1'b0);
            if (c == 5) check("bp_hold_y_early", yv[0], first_exp);
        end
        check("bp_accepted", 16'(n_acc[0] - acc0), 16'd3);
        check("bp_in_ready", 16'(irdy[0]), 16'd0);
        check("bp_out_valid", 16'(ov[0]), 16'd1);
        check("bp_hold_y", yv[0], first_exp);
        ordy[0] = 1'b1;
        run_stream(0, 50, 1'b0, "bp_drain");
        check("bp_drained", 16'(n_drn[0] - drn0), 16'd5);
        mon_en = 1'b0;

        // reset with two ops in flight
        ordy[0] = 1'b1;
        ia[0] = 16'h4040; ib[0] = 16'h4040; iv[0] = 1'b1; cyc();
        ia[0] = 16'h3F80; ib[0] = 16'h4000; cyc();
        iv[0] = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_mid_ov", 16'(ov[0]), 16'd0);
        check("rst_mid_y", yv[0], 16'h0000);
        check("rst_mid_ir", 16'(irdy[0]), 16'd1);
        cyc();
        reset = 1'b1;
        ghost = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (ov[0]) ghost++;
        end
        check("rst_mid_ghost", 16'(ghost), 16'd0);
        one_op(0, 16'h4040, 16'h4040, 16'h4110, "rst_after");

        // reset during a stall
        ordy[0] = 1'b0;
        ia[0] = 16'h4000; ib[0] = 16'h4000; iv[0] = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        iv[0] = 1'b0;
        check("stall_full", 16'(ov[0]), 16'd1);
        reset = 1'b0;
        #1;
        check("rst_stall_ov", 16'(ov[0]), 16'd0);
        check("rst_stall_y", yv[0], 16'h0000);
        cyc();
        reset = 1'b1;
        ordy[0] = 1'b1;
        ghost = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (ov[0]) ghost++;
        end
        check("rst_stall_ghost", 16'(ghost), 16'd0);

        // random streams with random backpressure and bubbles
        mon_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            drn0 = n_drn[d];
            for (int i = 0; i < 200; i++) begin
                logic [15:0] ra, rb;
                ra = 16'($urandom);
                rb = 16'($urandom);
                if (d == 0) begin
                    if ($urandom_range(0, 1) == 1) ra[14:7] = 8'($urandom_range(118, 136));
                    if ($urandom_range(0, 1) == 1) rb[14:7] = 8'($urandom_range(118, 136));
                end else begin
                    ra[15:8] = 8'h00;
                    rb[15:8] = 8'h00;
                end
                pend_a.push_back(ra);
                pend_b.push_back(rb);
            end
            run_stream(d, 3000, 1'b1, $sformatf("rand%0d", d));
            check($sformatf("rand%0d_count", d), 16'(n_drn[d] - drn0), 16'd200);
        end
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
